cacheline_mem_arbiter: RTL
==========================

// Module: cacheline_mem_arbiter
// PURPOSE
//  Shares the single cacheline-wide physical memory port between the I-cache miss port (read-only)
//  and the D-cache miss/writeback port. Sits between the L1 caches and pmem/L2.
//  Uses a 3-state FSM with registered grant, address and data, and round-robin or fixed priority.
//  Serves exactly one line transfer at a time; the response is passed back to the granted cache only.
// PARAMETERS
//  ADDR_W    32   byte address width (rv32i_word)
//  LINE_W    256  cacheline width in bits
//  PRIO_MODE 0    0 = round-robin on tie, 1 = D-cache always wins, 2 = I-cache always wins
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  i_read       in   1       I-cache line read request; held until i_resp
//  i_address    in   ADDR_W  I-cache line address
//  i_rdata      out  LINE_W  line returned to I-cache; valid when i_resp=1
//  i_resp       out  1       I-cache transfer complete (1 cycle)
//  d_read       in   1       D-cache line read request; held until d_resp
//  d_write      in   1       D-cache line writeback request; held until d_resp
//  d_address    in   ADDR_W  D-cache line address
//  d_wdata      in   LINE_W  D-cache writeback line
//  d_rdata      out  LINE_W  line returned to D-cache; valid when d_resp=1
//  d_resp       out  1       D-cache transfer complete (1 cycle)
//  mem_read     out  1       memory read strobe; held until mem_resp
//  mem_write    out  1       memory write strobe; held until mem_resp
//  mem_address  out  ADDR_W  registered line address; low log2(LINE_W/8) bits forced to 0
//  mem_wdata    out  LINE_W  registered writeback line
//  mem_rdata    in   LINE_W  memory read line
//  mem_resp     in   1       memory transfer complete (1 cycle)
//  proto_err    out  1       sticky flag: d_read & d_write seen together; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state = IDLE; last_grant = I.
//   - All outputs are 0: mem_*, i_/d_resp, i_/d_rdata, proto_err.
//   - Any in-flight transfer is abandoned; no resp is issued for it.
//  FSM states: IDLE, SERVE_I, SERVE_D.
//  IDLE:
//   - No request pending: stay in IDLE.
//   - Exactly one requester pending: grant that requester.
//   - Both pending, PRIO_MODE=0: grant the requester that is not last_grant.
//   - Both pending, PRIO_MODE=1/2: grant the fixed winner.
//   - On grant: register address (line-aligned), d_wdata and the direction; update last_grant.
//   - Next state is SERVE_x.
//  SERVE_x:
//   - mem_read or mem_write is driven from registered state; each is 1 for the whole state.
//   - Requester inputs are ignored after grant; changing them mid-transfer has no effect.
//   - On mem_resp: x_resp=1 and x_rdata=mem_rdata, combinationally in the same cycle;
//     next state is IDLE. The other resp stays 0.
//  Latency:
//   - Request sampled in IDLE at cycle t -> mem strobe asserted at t+1.
//   - mem_resp at cycle r -> x_resp at r; state is IDLE at r+1.
//   - Minimum 3 cycles per transfer; minimum 1 IDLE cycle between transfers.
//   - The IDLE bubble lets the requester drop its request after resp, so a stale request is never re-granted.
//  Data outputs:
//   - i_rdata/d_rdata are 0 whenever their resp is 0.
//   - mem_wdata is 0 for reads.
//  Boundary cases:
//   - mem_resp in IDLE is ignored.
//   - d_read and d_write both 1: treated as a write; proto_err is set.
//   - A request arriving while another is being served waits; it is granted in the next IDLE.
//   - Round-robin keeps waiting to at most 1 transfer when both caches request continuously.
// TESTING
//  1. Reset mid-transfer: rst_n=0 during SERVE_D -> all outputs 0 at once; after rst_n=1 the FSM is
//     IDLE and a pending d_read is re-granted with no spurious resp.
//  2. Single I read: i_read=1, i_address=0x0000_104C, mem_resp 5 cycles after the strobe ->
//     mem_address=0x0000_1040 and mem_read=1 from t+1; i_resp=1 and i_rdata=mem_rdata for one cycle;
//     d_resp stays 0.
//  3. Tie, PRIO_MODE=0, fresh from reset: i_read and d_read both held ->
//     grant order D, I, D, I across 4 transfers, with one IDLE cycle between each.
//  4. D writeback: d_write=1, d_address=0x8000_0020, d_wdata=pattern ->
//     mem_write=1, mem_wdata=pattern, mem_read=0; d_resp pulses once.
//  5. Fixed priority, PRIO_MODE=2: d_write and i_read held ->
//     I is served first every tie; D is served only when i_read=0 in IDLE.
//  6. Protocol errors: d_read=d_write=1 -> write is performed and proto_err=1 stays set;
//     a spurious mem_resp in IDLE -> no resp output and no state change.

Source files
------------

// File: rtl/cacheline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_mem_arbiter
// Purpose  : Shares one cacheline-wide memory port between the I-cache miss
//            port (read-only) and the D-cache miss/writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              proto_err
);

    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_d;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [LINE_W-1:0] r_mem_wdata;
    logic              r_proto_err;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_i_resp;
    logic w_d_resp;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // On a tie in round-robin mode the side that was not served last wins.
    always_comb begin
        w_grant_d = 1'b0;
        if (w_d_req && !w_i_req) begin
            w_grant_d = 1'b1;
        end else if (w_d_req && w_i_req) begin
            if (PRIO_MODE == 1) begin
                w_grant_d = 1'b1;
            end else if (PRIO_MODE == 2) begin
                w_grant_d = 1'b0;
            end else begin
                w_grant_d = !r_last_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_d      <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            if (d_read && d_write) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_i_req || w_d_req) begin
                        r_last_d <= w_grant_d;
                        if (w_grant_d) begin
                            // A simultaneous read+write is performed as a writeback.
                            r_state       <= ST_SERVE_D;
                            r_mem_read    <= !d_write;
                            r_mem_write   <= d_write;
                            r_mem_address <= d_address & c_ALIGN_MASK;
                            r_mem_wdata   <= d_write ? d_wdata : '0;
                        end else begin
                            r_state       <= ST_SERVE_I;
                            r_mem_read    <= 1'b1;
                            r_mem_write   <= 1'b0;
                            r_mem_address <= i_address & c_ALIGN_MASK;
                            r_mem_wdata   <= '0;
                        end
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (mem_resp) begin
                        r_state       <= ST_IDLE;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= '0;
                        r_mem_wdata   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_i_resp = (r_state == ST_SERVE_I) && mem_resp;
    assign w_d_resp = (r_state == ST_SERVE_D) && mem_resp;

    assign i_resp      = w_i_resp;
    assign d_resp      = w_d_resp;
    assign i_rdata     = w_i_resp ? mem_rdata : '0;
    assign d_rdata     = w_d_resp ? mem_rdata : '0;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire
